// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multi-cycle MIPS core: sequences ALU, regfile, memory port, PC and IR.
// Latency: 3-5 cycles per legal instruction (lw 5; sw/R/addi 4; beq/j 3), 2 cycles for an illegal one.
// Backpressure: none; the FSM advances every cycle and the datapath must keep up.
module mips_multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_t state_q, state_d;
    logic [5:0] opcode_q, funct_q;
    logic       funct_ok;

    // Raw (pre-reset-gating) strobes decoded from the state register
    logic       pc_write_r, pc_write_cond_r;
    logic       iord_r, mem_read_r, mem_write_r, ir_write_r;
    logic       reg_dst_r, mem_to_reg_r, reg_write_r, alu_src_a_r;
    logic [1:0] alu_src_b_r, pc_src_r;
    logic [2:0] alu_op_r, funct_alu;
    logic       instr_done_r, illegal_r;

    // Supported R-type function codes and their ALU mapping
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct_q)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_alu = ALU_ADD;
        endcase
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
            default:                               funct_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Capture the instruction fields in DECODE so later states ignore IR glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q <= '0;
            funct_q  <= '0;
        end else if (state_q == S_DECODE) begin
            opcode_q <= opcode;
            funct_q  <= funct;
        end
    end

    // Next-state and Moore strobe decode
    always_comb begin
        state_d         = S_FETCH;
        pc_write_r      = 1'b0;
        pc_write_cond_r = 1'b0;
        iord_r          = 1'b0;
        mem_read_r      = 1'b0;
        mem_write_r     = 1'b0;
        ir_write_r      = 1'b0;
        reg_dst_r       = 1'b0;
        mem_to_reg_r    = 1'b0;
        reg_write_r     = 1'b0;
        alu_src_a_r     = 1'b0;
        alu_src_b_r     = 2'b00;
        alu_op_r        = ALU_ADD;
        pc_src_r        = 2'b00;
        instr_done_r    = 1'b0;
        illegal_r       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_r  = 1'b1;
                ir_write_r  = 1'b1;
                alu_src_b_r = 2'b01;
                pc_write_r  = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut
                alu_src_b_r = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_RTYPE: begin
                        if (funct_ok) state_d = S_EXEC_R;
                        else          illegal_r = 1'b1;
                    end
                    default:      illegal_r = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_r = 1'b1;
                alu_src_b_r = 2'b10;
                state_d     = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read_r = 1'b1;
                iord_r     = 1'b1;
                state_d    = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_r  = 1'b1;
                mem_to_reg_r = 1'b1;
                instr_done_r = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_r  = 1'b1;
                iord_r       = 1'b1;
                instr_done_r = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_r = 1'b1;
                alu_op_r    = funct_alu;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_write_r  = 1'b1;
                reg_dst_r    = 1'b1;
                instr_done_r = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_r     = 1'b1;
                alu_op_r        = ALU_SUB;
                pc_src_r        = 2'b01;
                pc_write_cond_r = 1'b1;
                instr_done_r    = 1'b1;
            end
            S_JUMP: begin
                pc_src_r     = 2'b10;
                pc_write_r   = 1'b1;
                instr_done_r = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a_r = 1'b1;
                alu_src_b_r = 2'b10;
                state_d     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_r  = 1'b1;
                instr_done_r = 1'b1;
            end
            // Unused encodings recover to FETCH with every strobe low
            default: state_d = S_FETCH;
        endcase
    end

    // Reset forces every output low, including the combinational PC enable
    always_comb begin
        pc_en      = ~rst & (pc_write_r | (pc_write_cond_r & zero));
        iord       = ~rst & iord_r;
        mem_read   = ~rst & mem_read_r;
        mem_write  = ~rst & mem_write_r;
        ir_write   = ~rst & ir_write_r;
        reg_dst    = ~rst & reg_dst_r;
        mem_to_reg = ~rst & mem_to_reg_r;
        reg_write  = ~rst & reg_write_r;
        alu_src_a  = ~rst & alu_src_a_r;
        alu_src_b  = rst ? 2'b00 : alu_src_b_r;
        alu_op     = rst ? 3'b000 : alu_op_r;
        pc_src     = rst ? 2'b00 : pc_src_r;
        instr_done = ~rst & instr_done_r;
        illegal    = ~rst & illegal_r;
        state      = rst ? 4'd0 : state_q;
    end

    // Retired-instruction counter; wraps naturally, aborted instructions never reach instr_done
    always_ff @(posedge clk) begin
        if (rst)             instr_count <= '0;
        else if (instr_done) instr_count <= instr_count + 1'b1;
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: per-instruction table, expected per-cycle outputs queued
// when an instruction is driven and popped as the DUT walks its states.
module tb_mips_multicycle_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode, funct;
    logic             zero;
    logic             pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic             reg_write, alu_src_a, instr_done, illegal;
    logic [1:0]       alu_src_b, pc_src;
    logic [2:0]       alu_op;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       state;

    mips_multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .instr_done(instr_done), .illegal(illegal),
        .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       done, ill;
    } out_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         len;
        logic [3:0] path [5];
        logic       ill;
        logic [2:0] exop;
    } vec_t;

    vec_t       tbl [13];
    out_t       exp_q [$];
    int         errors = 0;
    int         checks = 0;
    logic [CNT_W-1:0] cnt_m;
    out_t       act;

    assign act = '{state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                   reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal};

    // Output table written straight from the state descriptions
    function automatic out_t exp_out(input logic [3:0] st, input logic ill,
                                     input logic [2:0] exop, input logic z);
        out_t o;
        o = '0;
        o.st = st;
        o.alu_op = 3'b010;
        case (st)
            4'd0:  begin o.mem_read = 1; o.ir_write = 1; o.src_b = 2'b01; o.pc_en = 1; end
            4'd1:  begin o.src_b = 2'b11; o.ill = ill; end
            4'd2:  begin o.src_a = 1; o.src_b = 2'b10; end
            4'd3:  begin o.mem_read = 1; o.iord = 1; end
            4'd4:  begin o.reg_write = 1; o.mem_to_reg = 1; o.done = 1; end
            4'd5:  begin o.mem_write = 1; o.iord = 1; o.done = 1; end
            4'd6:  begin o.src_a = 1; o.alu_op = exop; end
            4'd7:  begin o.reg_write = 1; o.reg_dst = 1; o.done = 1; end
            4'd8:  begin o.src_a = 1; o.alu_op = 3'b011; o.pc_src = 2'b01; o.pc_en = z; o.done = 1; end
            4'd9:  begin o.pc_src = 2'b10; o.pc_en = 1; o.done = 1; end
            4'd10: begin o.src_a = 1; o.src_b = 2'b10; end
            4'd11: begin o.reg_write = 1; o.done = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    // Enter at a negedge with the FSM in FETCH; leave at the negedge after the last state.
    // glitch_op (if not 6'hxx) replaces opcode once the instruction has left DECODE.
    task automatic run_instr(input vec_t v, input logic [5:0] glitch_op);
        out_t e;
        opcode = v.op;
        funct  = v.fn;
        zero   = v.z;
        for (int k = 0; k < v.len; k++) exp_q.push_back(exp_out(v.path[k], v.ill, v.exop, v.z));
        for (int k = 0; k < v.len; k++) begin
            if (k == 2 && !$isunknown(glitch_op)) opcode = glitch_op;
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s_cyc%0d_st%0d", v.name, k, v.path[k]), 32'(act), 32'(e));
            @(negedge clk);
        end
        if (!v.ill) cnt_m = cnt_m + 1'b1;
        #1;
        check($sformatf("%s_count", v.name), 32'(instr_count), 32'(cnt_m));
    endtask

    function automatic vec_t mk(input string nm, input logic [5:0] op, input logic [5:0] fn,
                                input logic z, input int len, input logic [19:0] p,
                                input logic ill, input logic [2:0] exop);
        vec_t v;
        v.name = nm; v.op = op; v.fn = fn; v.z = z; v.len = len; v.ill = ill; v.exop = exop;
        for (int i = 0; i < 5; i++) v.path[i] = p[19-4*i -: 4];
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0]  = mk("add",   6'h00, 6'h20, 0, 4, 20'h01670, 0, 3'b010);
        tbl[1]  = mk("sub",   6'h00, 6'h22, 1, 4, 20'h01670, 0, 3'b011);
        tbl[2]  = mk("and",   6'h00, 6'h24, 0, 4, 20'h01670, 0, 3'b000);
        tbl[3]  = mk("or",    6'h00, 6'h25, 0, 4, 20'h01670, 0, 3'b001);
        tbl[4]  = mk("slt",   6'h00, 6'h2a, 0, 4, 20'h01670, 0, 3'b100);
        tbl[5]  = mk("lw",    6'h23, 6'h00, 0, 5, 20'h01234, 0, 3'b010);
        tbl[6]  = mk("sw",    6'h2b, 6'h00, 0, 4, 20'h01250, 0, 3'b010);
        tbl[7]  = mk("beq_t", 6'h04, 6'h00, 1, 3, 20'h01800, 0, 3'b010);
        tbl[8]  = mk("beq_n", 6'h04, 6'h00, 0, 3, 20'h01800, 0, 3'b010);
        tbl[9]  = mk("j",     6'h02, 6'h00, 0, 3, 20'h01900, 0, 3'b010);
        tbl[10] = mk("addi",  6'h08, 6'h00, 0, 4, 20'h01ab0, 0, 3'b010);
        tbl[11] = mk("ill_op",6'h3f, 6'h20, 0, 2, 20'h01000, 1, 3'b010);
        tbl[12] = mk("ill_fn",6'h00, 6'h00, 0, 2, 20'h01000, 1, 3'b010);

        rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; cnt_m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", 32'(act), 32'h0);
        check("reset_count", 32'(instr_count), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        // Release was mid-low-phase; one posedge already executed FETCH, so resync with a reset pulse
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_instr(tbl[i], 6'hxx);

        // Opcode changes to sw after DECODE; the latched lw must still complete via S3/S4
        v = tbl[5]; v.name = "lw_glitch";
        run_instr(v, 6'h2b);

        // Reset during S3 of an lw aborts it without counting
        opcode = 6'h23; funct = 6'h00; zero = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("abort_lw_st%0d", k), 32'(act), 32'(exp_out(4'(k), 1'b0, 3'b010, 1'b0)));
            if (k == 3) rst = 1'b1;
            @(negedge clk);
        end
        #1;
        check("abort_outputs", 32'(act), 32'h0);
        check("abort_count", 32'(instr_count), 32'h0);
        cnt_m = '0;
        rst = 1'b0;
        run_instr(tbl[5], 6'hxx);

        // Counter wrap: bring count to all-ones then retire one more jump
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt_m = '0;
        for (int i = 0; i < 15; i++) run_instr(tbl[9], 6'hxx);
        check("count_full", 32'(instr_count), 32'd15);
        run_instr(tbl[9], 6'hxx);
        check("count_wrap", 32'(instr_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_controller.md
# mips_multicycle_controller

Main control FSM for the multi-cycle MIPS core. It sequences the shared datapath elements (ALU, register file, unified instruction/data memory port, PC, IR) across 3–5 cycles per instruction. Every datapath control strobe is produced here, along with a retired-instruction counter and an illegal-instruction flag. It sits beside the datapath top and consumes only the IR opcode/funct fields and the ALU zero flag.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `opcode`, in, 6: IR[31:26]. Valid from the cycle after FETCH.
- `funct`, in, 6: IR[5:0].
- `zero`, in, 1: ALU zero flag, combinational from the datapath.
- `pc_en`, out, 1: PC load enable, equal to `pc_write | (pc_write_cond & zero)`.
- `iord`, out, 1: memory address select; 0 selects PC, 1 selects ALUOut.
- `mem_read`, out, 1: memory read strobe.
- `mem_write`, out, 1: memory write strobe.
- `ir_write`, out, 1: IR load enable.
- `reg_dst`, out, 1: write-register select; 0 selects rt, 1 selects rd.
- `mem_to_reg`, out, 1: write-data select; 0 selects ALUOut, 1 selects MDR.
- `reg_write`, out, 1: register-file write enable.
- `alu_src_a`, out, 1: ALU A select; 0 selects PC, 1 selects register A.
- `alu_src_b`, out, 2: ALU B select; 00 is B, 01 is constant 4, 10 is sign-extended immediate, 11 is sign-extended immediate shifted left by 2.
- `alu_op`, out, 3: ALU operation; 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT.
- `pc_src`, out, 2: PC source; 00 is ALU result, 01 is ALUOut, 10 is jump target.
- `instr_done`, out, 1: one-cycle pulse in the last cycle of every legal instruction.
- `illegal`, out, 1: one-cycle pulse in DECODE when the opcode or funct is unsupported.
- `instr_count`, out, `CNT_W`: count of retired instructions.
- `state`, out, 4: current state, for debug.

## Operation
- Moore FSM. Outputs decode from the registered `state`, except `pc_en`, which also depends on `zero`. Any strobe not listed for a state is 0; `alu_op` defaults to ADD.
- Supported instructions:
  - opcode 000000 (R-type) with funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt;
  - 100011 lw; 101011 sw; 000100 beq; 000010 j; 001000 addi.
- States, with outputs → next state:
  - **S0 FETCH**: mem_read=1, iord=0, ir_write=1, src_a=0, src_b=01, ADD, pc_src=00, pc_write=1 → S1.
  - **S1 DECODE**: src_a=0, src_b=11, ADD (branch target into ALUOut) → next state by instruction:
    - lw or sw → S2;
    - valid R-type → S6;
    - beq → S8;
    - j → S9;
    - addi → S10;
    - otherwise assert `illegal` → S0.
  - **S2 MEM_ADDR**: src_a=1, src_b=10, ADD → S3 for lw, S5 for sw.
  - **S3 MEM_RD**: mem_read=1, iord=1 → S4.
  - **S4 MEM_WB**: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 → S0.
  - **S5 MEM_WR**: mem_write=1, iord=1, instr_done=1 → S0.
  - **S6 EXEC_R**: src_a=1, src_b=00, alu_op from funct (add→010, sub→011, and→000, or→001, slt→100) → S7.
  - **S7 R_WB**: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 → S0.
  - **S8 BRANCH**: src_a=1, src_b=00, SUB, pc_src=01, pc_write_cond=1, instr_done=1 → S0.
  - **S9 JUMP**: pc_src=10, pc_write=1, instr_done=1 → S0.
  - **S10 ADDI_EX**: src_a=1, src_b=10, ADD → S11.
  - **S11 ADDI_WB**: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 → S0.
  - State encodings 12–15 are unreachable; if entered, go to S0 with all strobes 0.
- `opcode` is latched into an internal register in S1. Later states decode from the latched copy, so an IR glitch cannot redirect the FSM mid-instruction.
- `instr_count` increments by 1 on each `instr_done` and wraps from all-ones to 0. An illegal instruction does not count.

## Timing
- Reset:
  - While `rst`=1, all outputs are forced to 0, including `pc_en`, `state`=0 and `instr_count`=0.
  - The first rising edge with `rst`=0 executes FETCH; the register values take effect after that edge.
- Reset asserted mid-instruction aborts it at the next edge. No further strobes are issued, and the counter is not incremented for the aborted instruction.
- Cycles per instruction:
  - lw 5;
  - sw, R-type and addi 4;
  - beq and j 3;
  - illegal 2 (FETCH, DECODE).
- `pc_en` in S8 follows `zero` combinationally within the same cycle. Branch taken and not-taken both take 3 cycles.
- `mem_read` and `mem_write` are never both 1 in the same cycle.
- `reg_write` is asserted in at most one cycle per instruction.

## Test plan
- After reset, a single `add` (opcode 000000, funct 100000) visits states 0,1,6,7. `reg_write`=1 and `reg_dst`=1 only in cycle 4. `instr_count` goes 0→1.
- `lw` then `sw` visits states 0,1,2,3,4 and then 0,1,2,5, a total of 9 cycles. `mem_to_reg`=1 in S4 only. `mem_write`=1 for exactly one cycle with `iord`=1. `instr_count`=2.
- `beq` with `zero`=1 gives `pc_en`=1 and `pc_src`=01 in S8. With `zero`=0, `pc_en`=0 in S8. Both cases return to S0 after 3 cycles.
- Opcode 111111 gives an `illegal` pulse in S1 and a return to S0. `instr_count` is unchanged and no write strobe is asserted.
- Assert `rst` in S3 of an `lw`: next cycle `state`=0, all strobes 0, `instr_count`=0. Release `rst`: FETCH strobes appear.
- Preload a count of 2^CNT_W−1 (CNT_W=4: run 15 `j`), then one more `j`: `instr_count` wraps to 0.
